// File: rtl/bin_to_bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (double dabble, one bit per clock); saturates to all-nines above 10^DIGITS-1.
// Latency: Start accepted at edge k -> BcdOut/Overflow/Done updated at edge k+BIN_W+1; back-to-back period BIN_W+2 edges.
// Backpressure: none; Start is accepted only in IDLE, dropped (not queued) while Busy; En=0 aborts. Optional macro: LEADING_ZERO_BLANK_EN adds DigitBlank.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  En,
   input  logic                  Start,
   input  logic [BIN_W-1:0]      BinIn,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Overflow,
   output logic [4*DIGITS-1:0]   BcdOut
`ifdef LEADING_ZERO_BLANK_EN
   ,
   output logic [DIGITS-1:0]     DigitBlank
`endif
);

   localparam int          BCD_W   = 4 * DIGITS;
   localparam int          CNT_W   = $clog2(BIN_W + 1);
   localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               load, shift_en, finish_en;
   logic [BIN_W-1:0]   shift_q;
   logic [BCD_W-1:0]   scratch_q;
   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   bcd_final;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_pend_q;

   // State register; synchronous reset overrides everything, including a conversion in flight.
   always_ff @(posedge Clk) begin
      if (!Rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode plus the per-cycle datapath strobes and Busy.
   always_comb begin
      state_d   = state_q;
      Busy      = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      finish_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (En && Start) begin
               load    = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            Busy = 1'b1;
            if (!En) begin
               state_d = S_IDLE;
            end else begin
               shift_en = 1'b1;
               // Counter value 1 means this edge performs the last shift.
               if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            Busy      = 1'b1;
            state_d   = S_IDLE;
            finish_en = En;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Add-3 correction: each digit independently, no carry between digits.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   // Result to publish: saturate to all nines when the input was out of range.
   always_comb begin
      bcd_final = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_d;

   // Blank digit i when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank_d  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run & (bcd_final[4*i +: 4] == 4'd0);
         blank_d[i] = zero_run;
      end
      blank_d[0] = 1'b0;
   end
`endif

   // Datapath: capture on accepted Start, shift while converting, publish on the FINISH edge.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         BcdOut     <= '0;
         Overflow   <= 1'b0;
         Done       <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         DigitBlank <= '0;
`endif
      end else begin
         Done <= 1'b0;
         if (load) begin
            shift_q    <= BinIn;
            scratch_q  <= '0;
            cnt_q      <= CNT_W'(BIN_W);
            ovf_pend_q <= (32'(BinIn) > MAX_VAL);
         end
         if (shift_en) begin
            // Top bit of the corrected scratch falls off; saturation covers that case.
            {scratch_q, shift_q} <= {adj[BCD_W-2:0], shift_q, 1'b0};
            cnt_q                <= cnt_q - CNT_W'(1);
         end
         if (finish_en) begin
            BcdOut   <= bcd_final;
            Overflow <= ovf_pend_q;
            Done     <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            DigitBlank <= blank_d;
`endif
         end
      end
   end

endmodule
